lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 750000, meaning power-up wait before the init sequence.
REQ-002 SHALL have parameter SETUP_CYC, default 2, meaning RS/DATA setup cycles before EN rises.
REQ-003 SHALL have parameter PULSE_CYC, default 12, meaning EN high cycles.
REQ-004 SHALL have parameter HOLD_CYC, default 2, meaning cycles RS/DATA are held after EN falls.
REQ-005 SHALL have parameter CMD_WAIT_CYC, default 2000, meaning execution wait for a normal command or data write.
REQ-006 SHALL have parameter CLR_WAIT_CYC, default 82000, meaning execution wait for a clear or home command.
REQ-007 SHALL have port i_clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-008 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port i_req_vld, input, 1 bit: a write request is present.
REQ-010 SHALL have port o_req_rdy, output, 1 bit: the controller accepts a request this cycle.
REQ-011 SHALL have port i_req_rs, input, 1 bit: 0 = command, 1 = data.
REQ-012 SHALL have port i_req_data, input, 8 bits: the command or character byte.
REQ-013 SHALL have port i_lcd_on, input, 1 bit: the backlight/enable request.
REQ-014 SHALL have port o_lcd, output, 32 bits, packed as [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA; all other bits are 0.
REQ-015 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port o_init_done, output, 1 bit: the init sequence has completed.

Function
REQ-017 FSM states SHALL be PWRUP, INIT, IDLE, SETUP, PULSE, HOLD and WAIT.
REQ-018 o_req_rdy SHALL be combinational and equal to (state==IDLE).
REQ-019 A transfer SHALL be accepted when i_req_vld && o_req_rdy at a rising edge; RS and DATA are latched on that edge.
REQ-020 While not ready, i_req_vld SHALL be ignored; the requester holds vld/rs/data stable until accepted.
REQ-021 After acceptance at edge k, the sequence SHALL be: SETUP for SETUP_CYC cycles (EN=0), then PULSE for PULSE_CYC cycles (EN=1), then HOLD for HOLD_CYC cycles (EN=0), then WAIT, then IDLE.
REQ-022 o_lcd[10] (EN) SHALL be registered and first high in the cycle after edge k+SETUP_CYC.
REQ-023 RS and DATA SHALL stay stable from SETUP through WAIT and keep their value in IDLE until the next acceptance.
REQ-024 RW SHALL always be 0.
REQ-025 The WAIT length SHALL be CLR_WAIT_CYC when rs==0 and data[7:2]==0 and data!=0; otherwise it is CMD_WAIT_CYC.
REQ-026 After reset, PWRUP SHALL last PWRUP_CYC cycles.
REQ-027 INIT SHALL then issue commands 0x38, 0x0C, 0x01, 0x06 (RS=0) in order, each through SETUP/PULSE/HOLD/WAIT.
REQ-028 After the fourth WAIT, the FSM SHALL go to IDLE, and o_init_done and o_req_rdy SHALL rise in the same cycle.
REQ-029 o_init_done SHALL stay 1 until reset.
REQ-030 o_lcd[31] SHALL equal i_lcd_on registered one cycle, independent of FSM state.
REQ-031 A single down-counter SHALL load (N-1) on each state entry and advance state on zero.
REQ-032 The counter width SHALL be $clog2 of the maximum parameter + 1.
REQ-033 All cycle parameters SHALL be >=1, checked by an elaboration-time assertion.

Reset
REQ-034 While i_rst=1 at an edge, the block SHALL set state=PWRUP, o_lcd=0, o_init_done=0, o_busy=1, o_req_rdy=0 and the counter to PWRUP_CYC-1.
REQ-035 A reset mid-transfer (any state) SHALL drop EN at the next edge, discard the transfer and restart the full power-up and init sequence.

Structure
REQ-036 Package lcd_pkg SHALL hold the state enum, the o_lcd bit-index constants (ON, EN, RS, RW, DATA range) and the 4-entry init command constant array.
REQ-037 The counter SHALL be sub-module lcd_timer (load value, load strobe, zero flag); everything else is in lcd_ctrl.

Verification (parameters 10/1/3/1/5/20)
REQ-038 Reset then release -> after 10 cycles, four EN pulses of exactly 3 cycles with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0; the 0x01 wait is 20 cycles; o_init_done=o_req_rdy=1 afterwards.
REQ-039 Request rs=1, data=0x41 -> EN high 3 cycles starting 2 cycles after acceptance; DATA=0x41 and RS=1 stable throughout; o_req_rdy low for 1+3+1+5 cycles.
REQ-040 Command 0x01 then command 0x80 -> the post-hold wait is 20 cycles, then 5 cycles.
REQ-041 i_req_vld held high with data changing while busy -> only the values present on ready cycles are transferred; no extra EN pulses occur.
REQ-042 Reset asserted during PULSE -> EN=0 at the next edge, o_init_done=0, and the init sequence replays from PWRUP.
REQ-043 Toggle i_lcd_on in any state -> o_lcd[31] follows exactly one cycle later.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } lcd_state_e;

   localparam int LCD_ON_BIT   = 31;
   localparam int LCD_EN_BIT   = 10;
   localparam int LCD_RS_BIT   = 9;
   localparam int LCD_RW_BIT   = 8;
   localparam int LCD_DATA_MSB = 7;
   localparam int LCD_DATA_LSB = 0;

   // Function set 8-bit/2-line, display on, clear, entry mode increment.
   localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that saturates at zero; shared by every timed state.
module lcd_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= RST_VAL;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: power-up delay, fixed init sequence, then
// request-driven command/data writes with SETUP/PULSE/HOLD/WAIT timing.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC    = 750000,
   parameter int SETUP_CYC    = 2,
   parameter int PULSE_CYC    = 12,
   parameter int HOLD_CYC     = 2,
   parameter int CMD_WAIT_CYC = 2000,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_vld,
   output logic        o_req_rdy,
   input  logic        i_req_rs,
   input  logic [7:0]  i_req_data,
   input  logic        i_lcd_on,
   output logic [31:0] o_lcd,
   output logic        o_busy,
   output logic        o_init_done
);

   localparam int MAX_CYC = max_int(max_int(max_int(PWRUP_CYC, SETUP_CYC),
                                            max_int(PULSE_CYC, HOLD_CYC)),
                                    max_int(CMD_WAIT_CYC, CLR_WAIT_CYC));
   localparam int TW = $clog2(MAX_CYC) + 1;

   localparam logic [TW-1:0] L_PWRUP = TW'(PWRUP_CYC - 1);
   localparam logic [TW-1:0] L_SETUP = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] L_PULSE = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] L_HOLD  = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] L_CMD   = TW'(CMD_WAIT_CYC - 1);
   localparam logic [TW-1:0] L_CLR   = TW'(CLR_WAIT_CYC - 1);

   generate
      if (PWRUP_CYC < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 ||
          CMD_WAIT_CYC < 1 || CLR_WAIT_CYC < 1) begin : g_bad_param
         $error("lcd_ctrl: every cycle parameter must be >= 1");
      end
   endgenerate

   lcd_state_e      r_state;
   logic            r_en;
   logic            r_rs;
   logic [7:0]      r_data;
   logic            r_on;
   logic            r_init_done;
   logic [1:0]      r_idx;

   logic            w_zero;
   logic            w_ld;
   logic [TW-1:0]   w_ld_val;
   logic            w_long;

   assign w_long = is_long_cmd(r_rs, r_data);

   // Counter reload happens on the same edge as the state change it times.
   always_comb begin
      w_ld     = 1'b0;
      w_ld_val = '0;
      unique case (r_state)
         ST_PWRUP: w_ld = w_zero;
         ST_INIT:  begin w_ld = 1'b1;      w_ld_val = L_SETUP; end
         ST_IDLE:  begin w_ld = i_req_vld; w_ld_val = L_SETUP; end
         ST_SETUP: begin w_ld = w_zero;    w_ld_val = L_PULSE; end
         ST_PULSE: begin w_ld = w_zero;    w_ld_val = L_HOLD;  end
         ST_HOLD:  begin w_ld = w_zero;    w_ld_val = w_long ? L_CLR : L_CMD; end
         ST_WAIT:  w_ld = w_zero;
         default:  ;
      endcase
   end

   lcd_timer #(.W(TW), .RST_VAL(L_PWRUP)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_ld),
      .i_load_val (w_ld_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_PWRUP;
         r_en        <= 1'b0;
         r_rs        <= 1'b0;
         r_data      <= 8'd0;
         r_on        <= 1'b0;
         r_init_done <= 1'b0;
         r_idx       <= 2'd0;
      end else begin
         r_on <= i_lcd_on;
         unique case (r_state)
            ST_PWRUP: if (w_zero) r_state <= ST_INIT;
            ST_INIT: begin
               r_rs    <= 1'b0;
               r_data  <= INIT_CMDS[r_idx];
               r_state <= ST_SETUP;
            end
            ST_IDLE: if (i_req_vld) begin
               r_rs    <= i_req_rs;
               r_data  <= i_req_data;
               r_state <= ST_SETUP;
            end
            ST_SETUP: if (w_zero) begin
               r_en    <= 1'b1;
               r_state <= ST_PULSE;
            end
            ST_PULSE: if (w_zero) begin
               r_en    <= 1'b0;
               r_state <= ST_HOLD;
            end
            ST_HOLD: if (w_zero) r_state <= ST_WAIT;
            ST_WAIT: if (w_zero) begin
               if (r_init_done) begin
                  r_state <= ST_IDLE;
               end else if (r_idx == 2'd3) begin
                  r_init_done <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_state <= ST_INIT;
               end
            end
            default: r_state <= ST_PWRUP;
         endcase
      end
   end

   assign o_req_rdy   = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_init_done = r_init_done;

   always_comb begin
      o_lcd                             = '0;
      o_lcd[LCD_ON_BIT]                 = r_on;
      o_lcd[LCD_EN_BIT]                 = r_en;
      o_lcd[LCD_RS_BIT]                 = r_rs;
      o_lcd[LCD_RW_BIT]                 = 1'b0;
      o_lcd[LCD_DATA_MSB:LCD_DATA_LSB]  = r_data;
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl with short timing parameters; per-cycle pin trace model.
module tb_lcd_ctrl;

  localparam int P_PWR = 10;
  localparam int P_SET = 1;
  localparam int P_PUL = 3;
  localparam int P_HLD = 1;
  localparam int P_CMD = 5;
  localparam int P_CLR = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        on = 1'b0;
  logic        rdy;
  logic [31:0] lcd;
  logic        busy;
  logic        done;

  lcd_ctrl #(
    .PWRUP_CYC    (P_PWR),
    .SETUP_CYC    (P_SET),
    .PULSE_CYC    (P_PUL),
    .HOLD_CYC     (P_HLD),
    .CMD_WAIT_CYC (P_CMD),
    .CLR_WAIT_CYC (P_CLR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_vld   (vld),
    .o_req_rdy   (rdy),
    .i_req_rs    (rs),
    .i_req_data  (data),
    .i_lcd_on    (on),
    .o_lcd       (lcd),
    .o_busy      (busy),
    .o_init_done (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // expected {EN, RS, RW, DATA} for each upcoming cycle of a transfer
  logic [10:0] exp_q[$];
  logic [8:0]  held;   // RS/DATA the pins keep while idle
  logic        m_rdy;  // model's view of ready in the current cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // One clock of normal operation; checks every output against the trace model.
  task automatic cycle(output logic acc);
    logic [10:0] e;
    logic        popped;
    int          nw;
    acc = vld && m_rdy;
    @(posedge clk); #1;
    if (acc) begin
      held = {rs, data};
      nw = (!rs && data >= 8'd1 && data <= 8'd3) ? P_CLR : P_CMD;
      for (int i = 0; i < P_SET; i++)      exp_q.push_back({1'b0, rs, 1'b0, data});
      for (int i = 0; i < P_PUL; i++)      exp_q.push_back({1'b1, rs, 1'b0, data});
      for (int i = 0; i < P_HLD + nw; i++) exp_q.push_back({1'b0, rs, 1'b0, data});
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped = 1'b1;
    end else begin
      e = {1'b0, held[8], 1'b0, held[7:0]};
      popped = 1'b0;
    end
    m_rdy = !popped;
    chk("lcd_pins", {21'd0, lcd[10:0]}, {21'd0, e});
    chk("req_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("busy", {31'd0, busy}, {31'd0, !m_rdy});
    chk("init_done_hold", {31'd0, done}, 32'd1);
    chk("lcd_on", {31'd0, lcd[31]}, {31'd0, on});
    chk("lcd_unused_bits", {12'd0, lcd[30:11]}, 32'd0);
    on = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string tag);
    logic acc;
    int   g = 0;
    while (!m_rdy && g < 200) begin
      cycle(acc);
      g++;
    end
    if (!m_rdy) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic send(input logic r, input logic [7:0] d);
    logic acc;
    int   g = 0;
    vld = 1'b1; rs = r; data = d;
    acc = 1'b0;
    while (!acc && g < 200) begin
      cycle(acc);
      g++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    vld = 1'b0;
    wait_idle("idle_timeout");
  endtask

  // Entered with rst=1; checks reset state, releases, then checks the init sequence.
  task automatic do_init();
    int          t;
    int          np;
    int          rise_t[8];
    int          fall_t[8];
    logic [7:0]  pd[8];
    logic        prev_en;
    logic        got;
    int          rdy_t;
    logic [7:0]  cmds[4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    @(posedge clk); #1;
    chk("rst_lcd", lcd, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    t = 0; np = 0; prev_en = 1'b0; got = 1'b0; rdy_t = 0;
    while (!got && t < 1000) begin
      @(posedge clk); #1;
      t++;
      chk("init_lcd_on", {31'd0, lcd[31]}, {31'd0, on});
      on = 1'($urandom_range(0, 1));
      if (lcd[10] && !prev_en && np < 8) begin
        rise_t[np] = t;
        pd[np] = lcd[7:0];
      end
      if (lcd[10]) begin
        chk("init_rs", {31'd0, lcd[9]}, 32'd0);
        if (np < 8) chk("init_data_stable", {24'd0, lcd[7:0]}, {24'd0, pd[np]});
      end
      if (!lcd[10] && prev_en) begin
        if (np < 8) fall_t[np] = t;
        np++;
      end
      prev_en = lcd[10];
      if (rdy) begin
        got = 1'b1;
        rdy_t = t;
        chk("init_done_with_rdy", {31'd0, done}, 32'd1);
      end else begin
        chk("init_done_early", {31'd0, done}, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd1);
      end
    end
    if (!got) chk("init_timeout", 32'd0, 32'd1);
    chk("init_pulse_count", np, 4);
    if (np == 4) begin
      chk("first_en_window",
          {31'd0, (rise_t[0] >= P_PWR + P_SET) && (rise_t[0] <= P_PWR + P_SET + 4)}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        chk("init_pulse_width", fall_t[i] - rise_t[i], P_PUL);
        chk("init_cmd", {24'd0, pd[i]}, {24'd0, cmds[i]});
      end
      chk("init_gap_short", rise_t[2] - fall_t[1], rise_t[1] - fall_t[0]);
      chk("init_clear_wait", (rise_t[3] - fall_t[2]) - (rise_t[1] - fall_t[0]), P_CLR - P_CMD);
      chk("init_last_wait", rdy_t - fall_t[3], P_HLD + P_CMD);
    end
    exp_q.delete();
    held  = {1'b0, 8'h06};
    m_rdy = 1'b1;
  endtask

  initial begin
    logic acc;
    int   g;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_init();

    for (int i = 0; i < 4; i++) cycle(acc);

    // data write, clear then set-address, home variants, short commands
    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b0, 8'h80);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b0, 8'h00);
    send(1'b1, 8'h01);
    send(1'b0, 8'h04);

    // random traffic: vld often held while busy, rs/data changing every cycle
    for (int c = 0; c < 400; c++) begin
      vld  = ($urandom_range(0, 3) != 0);
      rs   = 1'($urandom_range(0, 1));
      data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      cycle(acc);
    end
    vld = 1'b0;
    wait_idle("drain_timeout");

    // reset while EN is high
    vld = 1'b1; rs = 1'b1; data = 8'h55;
    g = 0;
    acc = 1'b0;
    while (!lcd[10] && g < 100) begin
      cycle(acc);
      if (acc) vld = 1'b0;
      g++;
    end
    vld = 1'b0;
    if (!lcd[10]) chk("pulse_wait_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_en", {31'd0, lcd[10]}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_lcd", lcd, 32'd0);
    chk("midrst_rdy", {31'd0, rdy}, 32'd0);
    do_init();

    send(1'b1, 8'h41);
    send(1'b0, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
